// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter with increment, jump, and subroutine
// call/return through an internal circular return-address stack.
// Optional build macro PC_STACK_ERR_EN: when defined, overflow/underflow
// are refused and flagged on a sticky err output; when undefined, overflow
// overwrites the oldest entry, underflow returns to address 0, and err is 0.
module pc_stack_unit #(
    parameter int PC_WIDTH    = 10,
    parameter int STACK_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               hold,
    input  logic                               s_inc,
    input  logic                               call,
    input  logic                               ret,
    input  logic [PC_WIDTH-1:0]                target,
    output logic [PC_WIDTH-1:0]                pc,
    output logic [PC_WIDTH-1:0]                tos,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               empty,
    output logic                               full,
    output logic                               err
);

    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam int PW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [DW-1:0] DEPTH_MAX = DW'(STACK_DEPTH);
    localparam logic [PW-1:0] LAST_PTR  = PW'(STACK_DEPTH - 1);

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] tos_q, tos_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [DW-1:0]       count_q, count_d;
    logic                empty_q, empty_d;
    logic                full_q, full_d;
    logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];
    logic [PC_WIDTH-1:0] stack_d [STACK_DEPTH];
`ifdef PC_STACK_ERR_EN
    logic                err_q, err_d;
`endif

    logic [PC_WIDTH-1:0] pc_inc_s;
    logic [PW-1:0]       ptr_inc_s;
    logic [PW-1:0]       ptr_dec_s;
    logic [PW-1:0]       ptr_dec2_s;

    // Wrapping pointer neighbours (depth need not be a power of two) and pc+1.
    always_comb begin
        pc_inc_s   = pc_q + PC_WIDTH'(1);
        ptr_inc_s  = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
        ptr_dec_s  = (wr_ptr_q == '0) ? LAST_PTR : wr_ptr_q - PW'(1);
        ptr_dec2_s = (ptr_dec_s == '0) ? LAST_PTR : ptr_dec_s - PW'(1);
    end

    // Next-state selection: hold > ret > call > jump > increment.
    always_comb begin
        pc_d     = pc_q;
        tos_d    = tos_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        stack_d  = stack_q;
`ifdef PC_STACK_ERR_EN
        err_d    = err_q;
`endif
        if (hold) begin
            pc_d = pc_q;
        end else if (ret) begin
            if (count_q != '0) begin
                pc_d     = tos_q;
                wr_ptr_d = ptr_dec_s;
                count_d  = count_q - DW'(1);
                // The entry beneath the popped one becomes the new top.
                tos_d    = (count_q > DW'(1)) ? stack_q[ptr_dec2_s] : '0;
            end else begin
`ifdef PC_STACK_ERR_EN
                pc_d  = pc_inc_s;
                err_d = 1'b1;
`else
                pc_d  = '0;
`endif
            end
        end else if (call) begin
            if (count_q != DEPTH_MAX) begin
                stack_d[wr_ptr_q] = pc_inc_s;
                wr_ptr_d          = ptr_inc_s;
                count_d           = count_q + DW'(1);
                tos_d             = pc_inc_s;
                pc_d              = target;
            end else begin
`ifdef PC_STACK_ERR_EN
                pc_d  = pc_inc_s;
                err_d = 1'b1;
`else
                // When full the write pointer sits on the oldest entry.
                stack_d[wr_ptr_q] = pc_inc_s;
                wr_ptr_d          = ptr_inc_s;
                tos_d             = pc_inc_s;
                pc_d              = target;
`endif
            end
        end else if (!s_inc) begin
            pc_d = target;
        end else begin
            pc_d = pc_inc_s;
        end
        empty_d = (count_d == '0);
        full_d  = (count_d == DEPTH_MAX);
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q     <= '0;
            tos_q    <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
`ifdef PC_STACK_ERR_EN
            err_q    <= 1'b0;
`endif
        end else begin
            pc_q     <= pc_d;
            tos_q    <= tos_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= stack_d[i];
            end
`ifdef PC_STACK_ERR_EN
            err_q    <= err_d;
`endif
        end
    end

    assign pc    = pc_q;
    assign tos   = tos_q;
    assign depth = count_q;
    assign empty = empty_q;
    assign full  = full_q;
`ifdef PC_STACK_ERR_EN
    assign err   = err_q;
`else
    assign err   = 1'b0;
`endif

endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
Parametrised program-counter unit for the next-generation microc datapath. It replaces the fixed PC register, incrementer and jump mux with one block. Adds subroutine call/return through an internal hardware return-address stack, plus a stall input. The control unit drives it with s_inc-style selects; pc addresses the program memory.

Parameters:
PC_WIDTH, 10, width of pc, jump target and stack entries
STACK_DEPTH, 4, number of return-address entries; legal range 2..16, need not be a power of 2

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
hold  input  1  1 = freeze pc and stack this cycle; highest priority
s_inc  input  1  1 = pc+1, 0 = load target (plain jump)
call  input  1  push return address pc+1, then load target
ret  input  1  pop top of stack into pc
target  input  PC_WIDTH  jump/call destination, from the instruction field
pc  output  PC_WIDTH  current program counter, registered
tos  output  PC_WIDTH  current top-of-stack entry; 0 when the stack is empty
depth  output  $clog2(STACK_DEPTH+1)  number of valid entries
empty  output  1  depth == 0
full  output  1  depth == STACK_DEPTH
err  output  1  sticky stack-error flag; see Optional Feature

Behaviour:
- Reset (asynchronous, any time, including mid-call/ret): pc=0, depth=0, empty=1, full=0, err=0, tos=0. Stack contents are don't-care.
- Every operation takes effect at the next rising edge. pc is registered, so the new pc is visible one cycle after the request. There is no combinational path from inputs to pc.
- Priority each cycle: hold > ret > call > (s_inc=0: jump) > (s_inc=1: increment).
- hold=1: no change to any state; call and ret are ignored and not queued.
- Increment: pc <= pc+1 mod 2^PC_WIDTH. With PC_WIDTH=10, 1023 wraps to 0.
- Jump (s_inc=0, no call/ret): pc <= target; stack untouched.
- Call, not full: stack[top] <= pc+1 (mod 2^PC_WIDTH); depth+1; pc <= target.
- Ret, not empty: pc <= tos; depth-1.
- call and ret together: ret wins and call is dropped. This is not an error.
- s_inc is ignored whenever call or ret is acted on.
- empty, full and depth are registered and consistent with the stack state in the same cycle.
- The stack is implemented as a circular buffer: a write pointer modulo STACK_DEPTH plus a saturating count.

Optional Feature:
Macro: PC_STACK_ERR_EN
- Defined:
  - call when full: no push, no jump; pc <= pc+1; err <= 1.
  - ret when empty: pc <= pc+1; err <= 1.
  - err is sticky and clears only on reset.
- Not defined:
  - call when full: the oldest entry is overwritten (circular); depth stays STACK_DEPTH; pc <= target.
  - ret when empty: pc <= 0; depth stays 0.
  - err is tied to 0.

Test Plan:
1. Reset at 5 ns, then s_inc=1 for 4 cycles -> pc 0,1,2,3,4; empty=1, depth=0.
2. At pc=4: s_inc=0, target=0x005 -> next pc=5. Then s_inc=1 -> pc=6; stack unchanged.
3. At pc=6: call target=0x100 -> pc=0x100, tos=7, depth=1. Two increments, then ret -> pc=7, empty=1.
4. Four nested calls (DEPTH=4) -> full=1, depth=4. Fifth call:
   - with PC_STACK_ERR_EN: pc=pc+1, err=1, depth=4.
   - without: pc=target, oldest entry lost; four rets return the four newest return addresses.
5. ret with empty stack:
   - with PC_STACK_ERR_EN: pc+1, err=1.
   - without: pc=0.
   Also: call and ret asserted together at depth=2 -> ret taken, depth=1. hold=1 with call asserted -> pc and depth unchanged.
6. Assert reset mid-sequence at depth=3, pc=0x1F0, asynchronously between edges -> pc=0 and depth=0 immediately. Also: pc=0x3FF with s_inc=1 -> pc=0x000.
